// File: rtl/rand_rom_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational random-value ROM.
// A free-running index counter is captured on grant, so press timing selects the ROM entry.
module rand_rom_arbiter #(
    parameter int N = 3,
    parameter int O = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req,
    output logic [1:0]   ack,
    output logic [O-1:0] data_out,
    output logic         busy,
    output logic [N-1:0] rom_addr,
    input  logic [O-1:0] rom_data
);

    typedef enum logic [1:0] {IDLE, READ, RELEASE} state_t;

    state_t       state;
    logic [N-1:0] cnt;
    logic         gnt;
    logic         last;
    logic         pick;

    // On a tie the requester that was not served last wins; otherwise the lone requester.
    always_comb begin
        pick = req[1];
        if (req == 2'b11)
            pick = ~last;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            rom_addr <= '0;
            data_out <= '0;
            ack      <= '0;
            gnt      <= 1'b0;
            last     <= 1'b1;
        end else begin
            cnt <= cnt + N'(1);
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        rom_addr <= cnt;
                        gnt      <= pick;
                        last     <= pick;
                        state    <= READ;
                    end
                end
                READ: begin
                    data_out <= rom_data;
                    ack      <= gnt ? 2'b10 : 2'b01;
                    state    <= RELEASE;
                end
                RELEASE: begin
                    ack <= '0;
                    if (!req[gnt])
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rand_rom_arbiter.sv
// Bench for rand_rom_arbiter: directed vector table, async-reset sequence,
// and randomized traffic against a transaction-level reference model.
module tb_rand_rom_arbiter;

    localparam int N = 3;
    localparam int O = 14;
    localparam logic [O-1:0] ROM [8] = '{14'd1, 14'd17, 14'd23, 14'd57,
                                         14'd234, 14'd9, 14'd4878, 14'd9999};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req = 2'b00;
    logic [1:0]   ack;
    logic [O-1:0] data_out;
    logic         busy;
    logic [N-1:0] rom_addr;
    logic [O-1:0] rom_data;

    int tests = 0;
    int fails = 0;

    rand_rom_arbiter #(.N(N), .O(O)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .ack      (ack),
        .data_out (data_out),
        .busy     (busy),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    always #5 clk = ~clk;
    assign rom_data = ROM[rom_addr];

    typedef struct {
        bit         rst;
        logic [1:0] req;
        int         rep;
        logic [1:0] ack;
        bit         busy;
        int         addr;
        int         data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] a, input bit b,
                              input int addr, input int data);
        check({tag, ".ack"}, 32'(ack), 32'(a));
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".rom_addr"}, 32'(rom_addr), 32'(addr));
        check({tag, ".data_out"}, 32'(data_out), 32'(data));
    endtask

    // Leaves rst_n released just after a falling edge: the next rising edge samples cnt=0.
    task automatic do_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        #1;
        check_outs("reset", 2'b00, 1'b0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic void add(bit rst, logic [1:0] r, int rep, logic [1:0] a,
                                bit b, int addr, int data);
        vec_t v;
        v.rst = rst; v.req = r; v.rep = rep; v.ack = a; v.busy = b; v.addr = addr; v.data = data;
        vecs.push_back(v);
    endfunction

    // Transaction-level reference: who owns the ROM, whether its fetch is still due,
    // and the round-robin memory. cnt is simply the number of edges since reset.
    int         m_owner;
    bit         m_fetch;
    int         m_last;
    int         m_cnt;
    int         m_addr;
    int         m_data;
    logic [1:0] m_ack;

    task automatic model_reset();
        m_owner = -1; m_fetch = 0; m_last = 1; m_cnt = 0;
        m_addr = 0; m_data = 0; m_ack = 2'b00;
    endtask

    task automatic model_edge(input logic [1:0] r);
        int g;
        m_ack = 2'b00;
        if (m_owner < 0) begin
            if (r != 2'b00) begin
                if (r == 2'b11) g = 1 - m_last;
                else            g = r[1] ? 1 : 0;
                m_owner = g;
                m_last  = g;
                m_addr  = m_cnt;
                m_fetch = 1;
            end
        end else if (m_fetch) begin
            m_data = int'(ROM[m_addr]);
            m_ack[m_owner] = 1'b1;
            m_fetch = 0;
        end else if (!r[m_owner]) begin
            m_owner = -1;
        end
        m_cnt = (m_cnt + 1) % 8;
    endtask

    task automatic run_random(input int cycles);
        int phase [2];
        int cd [2];
        int served_other [2];
        do_reset();
        model_reset();
        for (int i = 0; i < 2; i++) begin
            phase[i] = 0; cd[i] = $urandom_range(0, 3); served_other[i] = 0;
        end
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            model_edge(req);
            #1;
            check("rnd.ack", 32'(ack), 32'(m_ack));
            check("rnd.busy", 32'(busy), 32'(m_owner >= 0));
            check("rnd.rom_addr", 32'(rom_addr), 32'(m_addr));
            check("rnd.data_out", 32'(data_out), 32'(m_data));
            check("rnd.onehot", 32'(ack != 2'b11), 32'd1);
            for (int i = 0; i < 2; i++) begin
                if (ack[1-i] && phase[i] == 1)
                    served_other[i]++;
                if (ack[i]) begin
                    check("rnd.starve", 32'(served_other[i] <= 1), 32'd1);
                    served_other[i] = 0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                case (phase[i])
                    0: if (cd[i] == 0) begin req[i] = 1'b1; phase[i] = 1; end
                       else cd[i]--;
                    1: if (ack[i]) begin cd[i] = $urandom_range(0, 3); phase[i] = 2; end
                    default: if (cd[i] == 0) begin
                                 req[i] = 1'b0; cd[i] = $urandom_range(0, 4); phase[i] = 0;
                             end else cd[i]--;
                endcase
            end
        end
        req = 2'b00;
    endtask

    initial begin
        // Press at cnt=3 -> entry 57, single-cycle ack, busy until req[0] drops.
        add(1, 2'b00, 3, 2'b00, 0, 0, 0);
        add(0, 2'b01, 1, 2'b00, 1, 3, 0);
        add(0, 2'b01, 1, 2'b01, 1, 3, 57);
        add(0, 2'b01, 1, 2'b00, 1, 3, 57);
        add(0, 2'b00, 2, 2'b00, 0, 3, 57);
        // Tie after reset -> 0 first; tie again while 1 waits -> 1; then 0 alone.
        add(1, 2'b11, 1, 2'b00, 1, 0, 0);
        add(0, 2'b11, 1, 2'b01, 1, 0, 1);
        add(0, 2'b11, 1, 2'b00, 1, 0, 1);
        add(0, 2'b10, 1, 2'b00, 0, 0, 1);
        add(0, 2'b11, 1, 2'b00, 1, 4, 1);
        add(0, 2'b11, 1, 2'b10, 1, 4, 234);
        add(0, 2'b11, 1, 2'b00, 1, 4, 234);
        add(0, 2'b01, 1, 2'b00, 0, 4, 234);
        add(0, 2'b01, 1, 2'b00, 1, 0, 234);
        add(0, 2'b01, 1, 2'b01, 1, 0, 1);
        add(0, 2'b00, 1, 2'b00, 0, 0, 1);
        // Grant at cnt=7 -> 9999, then grant at cnt=0 after wrap -> 1.
        add(1, 2'b00, 7, 2'b00, 0, 0, 0);
        add(0, 2'b01, 1, 2'b00, 1, 7, 0);
        add(0, 2'b01, 1, 2'b01, 1, 7, 9999);
        add(0, 2'b00, 7, 2'b00, 0, 7, 9999);
        add(0, 2'b10, 1, 2'b00, 1, 0, 9999);
        add(0, 2'b10, 1, 2'b10, 1, 0, 1);
        add(0, 2'b00, 1, 2'b00, 0, 0, 1);
        // Held request: one ack only; drop one cycle and re-raise at cnt=7.
        add(1, 2'b01, 1, 2'b00, 1, 0, 0);
        add(0, 2'b01, 1, 2'b01, 1, 0, 1);
        add(0, 2'b01, 20, 2'b00, 1, 0, 1);
        add(0, 2'b00, 1, 2'b00, 0, 0, 1);
        add(0, 2'b01, 1, 2'b00, 1, 7, 1);
        add(0, 2'b01, 1, 2'b01, 1, 7, 9999);
        add(0, 2'b00, 1, 2'b00, 0, 7, 9999);

        for (int v = 0; v < vecs.size(); v++) begin
            if (vecs[v].rst)
                do_reset();
            for (int k = 0; k < vecs[v].rep; k++) begin
                req = vecs[v].req;
                @(posedge clk);
                #1;
                check_outs($sformatf("vec%0d", v), vecs[v].ack, vecs[v].busy,
                           vecs[v].addr, vecs[v].data);
            end
        end

        // Asynchronous reset while in READ: outputs clear at once, no ack, service resumes.
        req = 2'b10;
        @(posedge clk);
        #1;
        check_outs("async.grant", 2'b00, 1'b1, 2, 9999);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async.inrst", 2'b00, 1'b0, 0, 0);
        @(posedge clk);
        #1;
        check_outs("async.held", 2'b00, 1'b0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outs("async.regrant", 2'b00, 1'b1, 0, 0);
        @(posedge clk);
        #1;
        check_outs("async.ack", 2'b10, 1'b1, 0, 1);
        req = 2'b00;
        @(posedge clk);
        #1;
        check_outs("async.idle", 2'b00, 1'b0, 0, 1);

        run_random(10000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
